// File: rtl/fft_pkg.sv
//------------------------------------------------------------------------------
// fft_pkg -- shared state encoding, credit margin and default widths | Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  // Covers the two-cycle enable-to-address latency of the calculator.
  localparam int CREDIT_MARGIN = 3;

  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_FRAME_LEN  = 256;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;

endpackage

`default_nettype wire

// File: rtl/fft_fetch_fifo.sv
//------------------------------------------------------------------------------
// fft_fetch_fifo -- synchronous show-ahead FIFO with count/full/empty | Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fft_fetch_fifo
  import fft_pkg::*;
#(
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  // A full FIFO still takes a push when the same cycle pops.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !do_push));
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/fft_sample_fetch.sv
//------------------------------------------------------------------------------
// fft_sample_fetch -- reads calculator addresses into a credit FIFO, streams
// framed samples to the FFT. Define FFT_ZERO_PAD_EN to zero-pad the last frame.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fft_sample_fetch
  import fft_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              calc_en,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              addr_valid,
  input  logic              addr_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              sample_last,
  output logic              file_done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FRM_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_LEN - 1);
  localparam logic [CNT_W:0]   OCC_MAX  = (CNT_W + 1)'(FIFO_DEPTH - CREDIT_MARGIN);

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              addr_accept, rd_accept;
  logic              pad_active, file_end, drained, take, fifo_pop;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;

  fft_fetch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_accept),
    .push_data (mem_rd_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    addr_accept = addr_valid && (state_q == FETCH);
    // Returns with nothing outstanding are stale (e.g. issued before a reset).
    rd_accept   = mem_rd_valid && (outstanding_q != '0);
    occupancy   = {1'b0, fifo_count} + {1'b0, outstanding_q};
`ifdef FFT_ZERO_PAD_EN
    pad_active  = (state_q == DRAIN) && (outstanding_q == '0) && fifo_empty &&
                  (frame_cnt_q != '0);
    file_end    = 1'b0;
`else
    pad_active  = 1'b0;
    file_end    = (state_q == DRAIN) && (outstanding_q == '0) &&
                  (fifo_count == CNT_W'(1));
`endif
    drained     = (outstanding_q == '0) && fifo_empty && !pad_active;
    take        = (!fifo_empty || pad_active) && sample_ready;
    fifo_pop    = take && !fifo_empty;

    outstanding_d = outstanding_q + CNT_W'(addr_accept) - CNT_W'(rd_accept);

    frame_cnt_d = frame_cnt_q;
    if ((state_q == IDLE) && start) begin
      frame_cnt_d = '0;
    end else if (take) begin
      frame_cnt_d = frame_cnt_q + FRM_W'(1);
    end

    mem_rd_en_d = addr_accept;
    mem_addr_d  = addr_accept ? addr_in : mem_addr_q;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = FETCH;
      FETCH:   if (addr_done) state_d = DRAIN;
      DRAIN:   if (drained)   state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // FSM and stream outputs
  always_comb begin
    calc_en      = (state_q == FETCH) && (occupancy <= OCC_MAX);
    file_done    = (state_q == DONE);
    sample_valid = !fifo_empty || pad_active;
    sample_data  = pad_active ? '0 : fifo_head;
    sample_last  = sample_valid && ((frame_cnt_q == FRM_LAST) || file_end);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
      frame_cnt_q   <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      frame_cnt_q   <= frame_cnt_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mem_rd_valid && (outstanding_q == '0) && (state_q != IDLE)));
      assert (!(rd_accept && fifo_full && !fifo_pop));
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/fft_sample_fetch.md
# fft_sample_fetch

Stage directly downstream of `fft_address_calc`. It accepts the stream of sample addresses that block produces and issues one memory read per address. It buffers the in-order read data in a small credit-controlled FIFO and delivers samples to the FFT core on a valid/ready interface, marking frame boundaries. It also drives the calculator's `enable`, so address generation throttles to the available buffer space.

## Interface
- `FIFO_DEPTH`, 8: sample buffer entries; power of two, ≥4
- `FRAME_LEN`, 256: samples per FFT frame; power of two
- `ADDR_W`, 32: address width
- `DATA_W`, 32: sample width
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse; begins a file transfer; ignored unless IDLE
- `calc_en`  out  1  drives the calculator's `enable`
- `addr_in`  in  ADDR_W  sample address from the calculator
- `addr_valid`  in  1  `addr_in` valid this cycle; no backpressure, always accepted
- `addr_done`  in  1  the calculator's `done`; no further addresses follow
- `mem_rd_en`  out  1  read request strobe
- `mem_addr`  out  ADDR_W  read address
- `mem_rd_data`  in  DATA_W  read data
- `mem_rd_valid`  in  1  read data valid; any latency, strictly in order
- `sample_data`  out  DATA_W  sample to the FFT
- `sample_valid`  out  1  sample present
- `sample_ready`  in  1  FFT accepts the sample
- `sample_last`  out  1  final sample of a frame, or of the file
- `file_done`  out  1  one-cycle pulse when the transfer has fully drained

## Operation
- States:
  - IDLE –start→ FETCH.
  - FETCH –addr_done→ DRAIN.
  - DRAIN –(outstanding==0 && FIFO empty)→ DONE.
  - DONE → IDLE unconditionally, with `file_done`=1 during DONE.
- Accepted address: `addr_valid` in FETCH. `addr_valid` in any other state is dropped.
  - An address arriving in the same cycle as `addr_done` is accepted.
- Each accepted address produces a registered request: `mem_rd_en`=1 and `mem_addr`=`addr_in` on the next cycle. `outstanding` increments.
- `mem_rd_valid` writes `mem_rd_data` into the FIFO and decrements `outstanding`.
  - If `mem_rd_valid` arrives with `outstanding`==0, it is ignored; simulation assertion fires.
- Credit: `credit` = FIFO_DEPTH − fifo_count − outstanding.
  - `calc_en` = (state==FETCH) && (credit ≥ 3). The margin covers the 2-cycle enable-to-address latency.
  - Overflow of the FIFO is impossible by construction; an assertion checks it.
- FIFO is show-ahead. `sample_valid` = !empty, `sample_data` = head.
  - Pop on `sample_valid && sample_ready`.
  - Data and `sample_last` are held stable while stalled.
- Frame counter (log2 FRAME_LEN bits) increments per popped sample and wraps.
  - `sample_last`=1 when the counter equals FRAME_LEN−1.
  - `sample_last`=1 also on the final file sample (state DRAIN, outstanding==0, fifo_count==1).
- Width rules: counters are sized to hold FIFO_DEPTH inclusive. No arithmetic on addresses; passthrough only.
- `start` clears the frame counter.

## Timing
- Reset values: `calc_en`=0, `mem_rd_en`=0, `mem_addr`=0, `sample_valid`=0, `sample_last`=0, `file_done`=0, state IDLE, all counters 0.
- `addr_valid` at cycle t → `mem_rd_en` at t+1.
- `mem_rd_valid` at t → `sample_valid` at t+1 if the FIFO was empty.
- Simultaneous push and pop in one cycle: both occur and the count is unchanged; a full FIFO still accepts push-with-pop.
- `calc_en` deasserts the cycle after `credit` drops below 3.
- `reset` mid-transfer: everything returns to reset values on the next edge, and buffered data is discarded.
  - Late `mem_rd_valid` after reset is ignored, because `outstanding`==0.
- `start` outside IDLE: no effect.

## Configuration
- `FFT_ZERO_PAD_EN` defined: if the file ends mid-frame, the block emits zero samples after the last real sample until the frame counter reaches FRAME_LEN−1.
  - `sample_last` appears only on that final pad sample.
  - DONE is entered after the last pad sample is accepted.
- Undefined: no padding. `sample_last` marks the final real sample, so the final frame may be short.

## Structure
- Shared package `fft_pkg`: state enum (IDLE/FETCH/DRAIN/DONE), `CREDIT_MARGIN`=3 constant, default widths.
- One sub-module `fft_fetch_fifo`: synchronous show-ahead FIFO with push, pop, count, full, and empty.
- Credit logic, FSM, and frame counter live in the top level.

## Test plan
- Reset, start, 10 addresses 0..9, memory latency 3, `sample_ready`=1.
  - Required: 10 `mem_rd_en` pulses with the matching addresses.
  - Samples in order; `sample_last` on the 10th; `file_done` once.
  - With `FFT_ZERO_PAD_EN`: 246 zero samples follow, and the last one carries `sample_last`.
- Hold `sample_ready`=0 with a continuous address stream.
  - Required: `calc_en` drops, and fifo_count + outstanding never exceeds 8.
  - Release: all samples are delivered with no loss or duplication.
- 512-address file.
  - Required: `sample_last` on samples 256 and 512 only; no padding in either configuration.
- `addr_valid` and `addr_done` asserted in the same cycle as the 5th address.
  - Required: 5 reads issued, then DRAIN, then DONE.
- Assert `reset` with 3 reads outstanding, then return their data.
  - Required: outputs at reset values; the returned data is ignored; no `sample_valid`.
- `start` pulsed during FETCH.
  - Required: frame counter is not cleared and the state is unchanged.
